// File: rtl/sram_port_arbiter.sv
// Two-port sequencer for the 8-bit async SRAM: 32-bit video word reads and single-byte writes.
// Build option SRAM_WAITSTATE_EN stretches each read byte and the write strobe to two cycles.
module sram_port_arbiter #(
    parameter int ADDR_W = 19
) (
    input  logic              clk_sys,
    input  logic              rst_n,
    input  logic              vid_req,
    input  logic [ADDR_W-3:0] vid_addr,
    output logic [31:0]       vid_q,
    output logic              vid_ack,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    output logic              wr_ack,
    output logic              busy,
    output logic [ADDR_W-1:0] sram_addr,
    inout  wire  [7:0]        sram_dq,
    output logic              sram_we_n,
    output logic              sram_oe_n
);

    typedef enum logic [2:0] {
        S_IDLE, S_RD0, S_RD1, S_RD2, S_RD3, S_WR_SETUP, S_WR_PULSE, S_WR_HOLD
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              drv_en_q, drv_en_d;
    logic              we_n_q, we_n_d;
    logic              oe_n_q, oe_n_d;
    logic [23:0]       rd_buf_q, rd_buf_d;
    logic [31:0]       vid_word_q, vid_word_d;
    logic              vid_ack_q, vid_ack_d;
    logic              wr_ack_q, wr_ack_d;
    logic              last_vid_q, last_vid_d;
    logic              step;

`ifdef SRAM_WAITSTATE_EN
    logic ws_q, ws_d;

    // Wait-state phase: first cycle of a stretched state holds, second one advances.
    always_comb begin
        ws_d = 1'b0;
        if (state_q inside {S_RD0, S_RD1, S_RD2, S_RD3, S_WR_PULSE}) ws_d = !ws_q;
    end
    assign step = ws_q;
`else
    assign step = 1'b1;
`endif

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        drv_en_d   = drv_en_q;
        we_n_d     = we_n_q;
        oe_n_d     = oe_n_q;
        rd_buf_d   = rd_buf_q;
        vid_word_d = vid_word_q;
        vid_ack_d  = 1'b0;
        wr_ack_d   = 1'b0;
        last_vid_d = last_vid_q;
        case (state_q)
            S_IDLE: begin
                // Video wins a tie unless it took the previous grant.
                if (vid_req && (!wr_req || !last_vid_q)) begin
                    state_d    = S_RD0;
                    addr_d     = {vid_addr, 2'b00};
                    oe_n_d     = 1'b0;
                    last_vid_d = 1'b1;
                end else if (wr_req) begin
                    state_d    = S_WR_SETUP;
                    addr_d     = wr_addr;
                    wdata_d    = wr_data;
                    drv_en_d   = 1'b1;
                    oe_n_d     = 1'b1;
                    last_vid_d = 1'b0;
                end
            end
            S_RD0, S_RD1, S_RD2: begin
                if (step) begin
                    rd_buf_d    = {rd_buf_q[15:0], sram_dq};
                    addr_d[1:0] = addr_q[1:0] + 2'd1;
                    state_d     = (state_q == S_RD0) ? S_RD1 :
                                  (state_q == S_RD1) ? S_RD2 : S_RD3;
                end
            end
            S_RD3: begin
                if (step) begin
                    vid_word_d  = {rd_buf_q, sram_dq};
                    vid_ack_d   = 1'b1;
                    oe_n_d      = 1'b1;
                    addr_d[1:0] = addr_q[1:0] + 2'd1;
                    state_d     = S_IDLE;
                end
            end
            S_WR_SETUP: begin
                we_n_d  = 1'b0;
                state_d = S_WR_PULSE;
            end
            S_WR_PULSE: begin
                if (step) begin
                    we_n_d   = 1'b1;
                    wr_ack_d = 1'b1;
                    state_d  = S_WR_HOLD;
                end
            end
            S_WR_HOLD: begin
                drv_en_d = 1'b0;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            drv_en_q   <= 1'b0;
            we_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            rd_buf_q   <= '0;
            vid_word_q <= '0;
            vid_ack_q  <= 1'b0;
            wr_ack_q   <= 1'b0;
            last_vid_q <= 1'b0;
`ifdef SRAM_WAITSTATE_EN
            ws_q       <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            drv_en_q   <= drv_en_d;
            we_n_q     <= we_n_d;
            oe_n_q     <= oe_n_d;
            rd_buf_q   <= rd_buf_d;
            vid_word_q <= vid_word_d;
            vid_ack_q  <= vid_ack_d;
            wr_ack_q   <= wr_ack_d;
            last_vid_q <= last_vid_d;
`ifdef SRAM_WAITSTATE_EN
            ws_q       <= ws_d;
`endif
        end
    end

    assign sram_dq   = drv_en_q ? wdata_q : 8'hzz;
    assign sram_addr = addr_q;
    assign sram_we_n = we_n_q;
    assign sram_oe_n = oe_n_q;
    assign vid_q     = vid_word_q;
    assign vid_ack   = vid_ack_q;
    assign wr_ack    = wr_ack_q;
    assign busy      = (state_q != S_IDLE);

endmodule
